// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flow controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } pipeState_e;

   localparam int unsigned DRAIN_CYCLES    = 3;
   localparam int unsigned FILL_CYCLES_DEF = 4;
   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned SEQ_W           = 4;
   localparam int unsigned REG_W           = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, stage enables/clears and debug/perf outputs of pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       rs1_de;
   logic [4:0]       rs2_de;
   logic [4:0]       rd_ex;
   logic             DMRd_ex;
   logic             RuWr_ex;
   logic             br_taken_ex;
   logic             mem_busy;
   logic             halt_req;

   logic             pc_en;
   logic             fd_en;
   logic             fd_clr;
   logic             dx_en;
   logic             dx_clr;
   logic             xm_en;
   logic             mw_en;
   logic             mw_clr;
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_de, rs2_de, rd_ex, DMRd_ex, RuWr_ex, br_taken_ex, mem_busy, halt_req,
      input  pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, mw_en, mw_clr,
      input  halted, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_de, rs2_de, rd_ex, DMRd_ex, RuWr_ex, br_taken_ex, mem_busy, halt_req,
      output pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, mw_en, mw_clr,
      output halted, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source in DE.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs1De,
   input  logic [REG_W-1:0] rs2De,
   input  logic [REG_W-1:0] rdEx,
   input  logic             dmRdEx,
   input  logic             ruWrEx,
   output logic             loadUse_c
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   always_comb begin
      loadUse_c = dmRdEx & ruWrEx & (rdEx != REG_W'(0)) &
                  ((rdEx == rs1De) | (rdEx == rs2De));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline flow controller: fill after reset, stall/flush in run, drain to halt.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FILL_CYCLES = FILL_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.slave bus
);

   localparam logic [1:0]       StFill   = FILL;
   localparam logic [1:0]       StRun    = RUN;
   localparam logic [1:0]       StDrain  = DRAIN;
   localparam logic [1:0]       StHalted = HALTED;
   localparam logic [SEQ_W-1:0] FillLoad  = SEQ_W'(FILL_CYCLES - 1);
   localparam logic [SEQ_W-1:0] DrainLoad = SEQ_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

   logic [1:0]       stateQ, stateD;
   logic [SEQ_W-1:0] seqQ, seqD;
   logic [CNT_W-1:0] stallCntQ, flushCntQ;
   logic             stallInc, flushInc;
   logic             loadUse;

   hazard_detect u_hazard (
      .rs1De     (bus.rs1_de),
      .rs2De     (bus.rs2_de),
      .rdEx      (bus.rd_ex),
      .dmRdEx    (bus.DMRd_ex),
      .ruWrEx    (bus.RuWr_ex),
      .loadUse_c (loadUse)
   );

   // State, shared fill/drain sequence counter and saturating perf counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ    <= StFill;
         seqQ      <= FillLoad;
         stallCntQ <= '0;
         flushCntQ <= '0;
      end else begin
         stateQ <= stateD;
         seqQ   <= seqD;
         if (stallInc && (stallCntQ != CntMax)) stallCntQ <= stallCntQ + CNT_W'(1);
         if (flushInc && (flushCntQ != CntMax)) flushCntQ <= flushCntQ + CNT_W'(1);
      end
   end

   // Next state and Mealy stage controls
   always_comb begin
      stateD     = stateQ;
      seqD       = seqQ;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
      bus.pc_en  = 1'b0;
      bus.fd_en  = 1'b0;
      bus.fd_clr = 1'b0;
      bus.dx_en  = 1'b0;
      bus.dx_clr = 1'b0;
      bus.xm_en  = 1'b0;
      bus.mw_en  = 1'b0;
      bus.mw_clr = 1'b0;
      bus.halted = 1'b0;

      case (stateQ)
         StFill: begin
            bus.fd_clr = 1'b1;
            bus.dx_clr = 1'b1;
            bus.mw_clr = 1'b1;
            bus.xm_en  = 1'b1;
            if (seqQ == SEQ_W'(0)) stateD = StRun;
            else                   seqD   = seqQ - SEQ_W'(1);
         end

         StRun: begin
            if (bus.mem_busy) begin
               // Whole front end holds; a pending branch is re-seen once ME frees up
               bus.mw_clr = 1'b1;
               stallInc   = 1'b1;
            end else if (loadUse) begin
               bus.dx_clr = 1'b1;
               bus.xm_en  = 1'b1;
               bus.mw_en  = 1'b1;
               stallInc   = 1'b1;
            end else if (bus.br_taken_ex) begin
               bus.pc_en  = 1'b1;
               bus.fd_en  = 1'b1;
               bus.dx_en  = 1'b1;
               bus.xm_en  = 1'b1;
               bus.mw_en  = 1'b1;
               bus.fd_clr = 1'b1;
               bus.dx_clr = 1'b1;
               flushInc   = 1'b1;
            end else if (bus.halt_req) begin
               bus.fd_en  = 1'b1;
               bus.dx_en  = 1'b1;
               bus.xm_en  = 1'b1;
               bus.mw_en  = 1'b1;
               bus.fd_clr = 1'b1;
               seqD       = DrainLoad;
               stateD     = StDrain;
            end else begin
               bus.pc_en = 1'b1;
               bus.fd_en = 1'b1;
               bus.dx_en = 1'b1;
               bus.xm_en = 1'b1;
               bus.mw_en = 1'b1;
            end
         end

         StDrain: begin
            if (bus.mem_busy) begin
               bus.mw_clr = 1'b1;
            end else begin
               bus.fd_en  = 1'b1;
               bus.dx_en  = 1'b1;
               bus.xm_en  = 1'b1;
               bus.mw_en  = 1'b1;
               bus.fd_clr = 1'b1;
               if (seqQ == SEQ_W'(0)) stateD = StHalted;
               else                   seqD   = seqQ - SEQ_W'(1);
            end
         end

         default: begin
            bus.halted = 1'b1;
            if (!bus.halt_req) stateD = StRun;
         end
      endcase
   end

   assign bus.state     = stateQ;
   assign bus.stall_cnt = stallCntQ;
   assign bus.flush_cnt = flushCntQ;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven check of pipeline_ctrl (CNT_W=4 build for saturation).
module tb_pipeline_ctrl;

   localparam int unsigned CW = 4;

   // {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_en, mw_en, mw_clr}
   localparam logic [7:0] C_FILL = 8'b0010_1101;
   localparam logic [7:0] C_NORM = 8'b1101_0110;
   localparam logic [7:0] C_BUSY = 8'b0000_0001;
   localparam logic [7:0] C_LDU  = 8'b0000_1110;
   localparam logic [7:0] C_BR   = 8'b1111_1110;
   localparam logic [7:0] C_DRN  = 8'b0111_0110;
   localparam logic [7:0] C_HLT  = 8'b0000_0000;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       dmrd, ruwr, br, busy, halt;
      logic [7:0] ctrl;
      logic [1:0] st;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nTests = 0;
   int   nFail  = 0;

   pipeline_ctrl_if #(.CNT_W(CW)) ifc ();

   pipeline_ctrl #(.FILL_CYCLES(4), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] ctrlAct;
   assign ctrlAct = {ifc.pc_en, ifc.fd_en, ifc.fd_clr, ifc.dx_en,
                     ifc.dx_clr, ifc.xm_en, ifc.mw_en, ifc.mw_clr};

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic dmrd, input logic ruwr,
                               input logic br, input logic busy, input logic halt,
                               input logic [7:0] ctrl, input logic [1:0] st);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.dmrd = dmrd; v.ruwr = ruwr;
      v.br = br; v.busy = busy; v.halt = halt; v.ctrl = ctrl; v.st = st;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ifc.rs1_de      = v.rs1;
      ifc.rs2_de      = v.rs2;
      ifc.rd_ex       = v.rd;
      ifc.DMRd_ex     = v.dmrd;
      ifc.RuWr_ex     = v.ruwr;
      ifc.br_taken_ex = v.br;
      ifc.mem_busy    = v.busy;
      ifc.halt_req    = v.halt;
   endtask

   // Called at a negedge: drive, check the combinational response, advance one cycle
   task automatic applyVec(input vec_t v, input string tag);
      drive(v);
      #1;
      check({tag, ".ctrl"},   32'(ctrlAct),    32'(v.ctrl));
      check({tag, ".state"},  32'(ifc.state),  32'(v.st));
      check({tag, ".halted"}, 32'(ifc.halted), 32'(v.st == 2'd3));
      @(negedge clk);
   endtask

   vec_t vecs [23];
   vec_t idle, bsy, hlt, hltBusy;

   initial begin
      idle    = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd1);
      bsy     = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_BUSY, 2'd1);
      hlt     = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN,  2'd1);
      hltBusy = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_BUSY, 2'd2);

      for (int i = 0; i < 4; i++)
         vecs[i] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FILL, 2'd0);
      vecs[4]  = idle;
      vecs[5]  = mk(5'd9, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LDU,  2'd1);
      vecs[6]  = idle;
      vecs[7]  = mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 2'd1);
      vecs[8]  = mk(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2'd1);
      vecs[9]  = mk(5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LDU,  2'd1);
      vecs[10] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd1);
      vecs[11] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_BUSY, 2'd1);
      vecs[12] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_BUSY, 2'd1);
      vecs[13] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   2'd1);
      vecs[14] = mk(5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, C_BUSY, 2'd1);
      vecs[15] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_BR,   2'd1);
      vecs[16] = hlt;
      vecs[17] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN,  2'd2);
      vecs[18] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_DRN,  2'd2);
      vecs[19] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN,  2'd2);
      vecs[20] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_HLT,  2'd3);
      vecs[21] = mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HLT,  2'd3);
      vecs[22] = idle;

      // Reset values
      drive(idle);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst.ctrl",   32'(ctrlAct),       32'(C_FILL));
      check("rst.state",  32'(ifc.state),     32'd0);
      check("rst.halted", 32'(ifc.halted),    32'd0);
      check("rst.stall",  32'(ifc.stall_cnt), 32'd0);
      check("rst.flush",  32'(ifc.flush_cnt), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) applyVec(vecs[i], $sformatf("vec%0d", i));
      check("tbl.stall", 32'(ifc.stall_cnt), 32'd5);
      check("tbl.flush", 32'(ifc.flush_cnt), 32'd3);

      // Drain stretched by two busy cycles: 3 + 2 DRAIN cycles before HALTED
      applyVec(hlt, "dbusy.req");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN, 2'd2), "dbusy.d0");
      applyVec(hltBusy, "dbusy.b0");
      applyVec(hltBusy, "dbusy.b1");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN, 2'd2), "dbusy.d1");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN, 2'd2), "dbusy.d2");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_HLT, 2'd3), "dbusy.h0");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_HLT, 2'd3), "dbusy.h1");
      applyVec(idle, "dbusy.run");
      check("dbusy.stall", 32'(ifc.stall_cnt), 32'd5);

      // Saturation: 20 busy cycles from 5 must stop at 15
      for (int i = 0; i < 20; i++) applyVec(bsy, $sformatf("sat%0d", i));
      check("sat.stall", 32'(ifc.stall_cnt), 32'd15);
      applyVec(bsy, "sat.extra");
      check("sat.hold",  32'(ifc.stall_cnt), 32'd15);
      check("sat.flush", 32'(ifc.flush_cnt), 32'd3);

      // Asynchronous reset in the middle of a drain
      applyVec(hlt, "rdrn.req");
      applyVec(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DRN, 2'd2), "rdrn.d0");
      #2 rst = 1'b1;
      #1;
      check("rdrn.state", 32'(ifc.state),     32'd0);
      check("rdrn.ctrl",  32'(ctrlAct),       32'(C_FILL));
      check("rdrn.halt",  32'(ifc.halted),    32'd0);
      check("rdrn.stall", 32'(ifc.stall_cnt), 32'd0);
      check("rdrn.flush", 32'(ifc.flush_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) applyVec(vecs[i], $sformatf("refill%0d", i));
      applyVec(idle, "refill.run");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
